// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus load-use / multi-cycle RAW hazard detection.
// Tracks one outstanding MUL/DIV writeback with a per-register pending scoreboard.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  mc_ID,
  input  logic [REG_ADDR_W-1:0] rs1_ID_EX,
  input  logic [REG_ADDR_W-1:0] rs2_ID_EX,
  input  logic [REG_ADDR_W-1:0] rd_ID_EX,
  input  logic                  reg_write_ID_EX,
  input  logic                  mem_read_ID_EX,
  input  logic [REG_ADDR_W-1:0] rd_EX_MEM,
  input  logic                  reg_write_EX_MEM,
  input  logic [REG_ADDR_W-1:0] rd_MEM_WB,
  input  logic                  reg_write_MEM_WB,
  input  logic                  mc_issue,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic                  mc_done,
  output logic [1:0]            forward_A,
  output logic [1:0]            forward_B,
  output logic                  stall,
  output logic                  flush_ID_EX,
  output logic                  mc_busy,
  output logic                  mc_timeout,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int BW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_BUSY} mc_state_e;

  mc_state_e               state_q, state_d;
  logic [REG_ADDR_W-1:0]   mc_rd_q, mc_rd_d;
  logic [NUM_REGS-1:0]     pending_q, pending_d;
  logic [BW-1:0]           busy_cnt_q, busy_cnt_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic                    lu, raw;

  // Nearest producer wins, but only when it actually targets this source register.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (reg_write_EX_MEM && rd_EX_MEM != '0 && rd_EX_MEM == rs)      return 2'b10;
    else if (reg_write_MEM_WB && rd_MEM_WB != '0 && rd_MEM_WB == rs) return 2'b01;
    else                                                             return 2'b00;
  endfunction

  assign forward_A = fwd_sel(rs1_ID_EX);
  assign forward_B = fwd_sel(rs2_ID_EX);

  assign mc_busy = (state_q == S_BUSY);

  assign lu  = mem_read_ID_EX && reg_write_ID_EX && (rd_ID_EX != '0) &&
               ((rd_ID_EX == rs1_ID) || (rd_ID_EX == rs2_ID));
  assign raw = ((rs1_ID != '0) && pending_q[rs1_ID]) ||
               ((rs2_ID != '0) && pending_q[rs2_ID]);

  assign stall       = lu || raw || (mc_ID && mc_busy);
  assign flush_ID_EX = stall;
  assign mc_timeout  = timeout_q;
  assign stall_cnt   = stall_cnt_q;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    mc_rd_d = mc_rd_q;
    unique case (state_q)
      S_IDLE: if (mc_issue) begin
        state_d = S_BUSY;
        mc_rd_d = mc_rd;
      end
      S_BUSY: begin
        if (mc_issue)     mc_rd_d = mc_rd;
        else if (mc_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Clear is applied before set so a same-register set in the same cycle wins.
  always_comb begin
    pending_d = pending_q;
    if (mc_busy && mc_done)        pending_d[mc_rd_q] = 1'b0;
    if (mc_issue && mc_rd != '0)   pending_d[mc_rd]   = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (mc_issue)                                     busy_cnt_d = '0;
    else if (mc_busy && busy_cnt_q != BW'(MC_TIMEOUT)) busy_cnt_d = busy_cnt_q + 1'b1;
    timeout_d = timeout_q || (busy_cnt_d == BW'(MC_TIMEOUT));
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; the scoreboard is a
  // flop vector (not a RAM), so resetting it is cheap and abandons any outstanding op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mc_rd_q     <= '0;
      pending_q   <= '0;
      busy_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_rd_q     <= mc_rd_d;
      pending_q   <= pending_d;
      busy_cnt_q  <= busy_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use, scoreboard RAW,
// watchdog and asynchronous reset, each with hand-computed expectations.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_ID, rs2_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX, rd_EX_MEM, rd_MEM_WB, mc_rd;
  logic        mc_ID, reg_write_ID_EX, mem_read_ID_EX, reg_write_EX_MEM, reg_write_MEM_WB;
  logic        mc_issue, mc_done;
  logic [1:0]  forward_A, forward_B;
  logic        stall, flush_ID_EX, mc_busy, mc_timeout;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .mc_ID(mc_ID),
    .rs1_ID_EX(rs1_ID_EX), .rs2_ID_EX(rs2_ID_EX), .rd_ID_EX(rd_ID_EX),
    .reg_write_ID_EX(reg_write_ID_EX), .mem_read_ID_EX(mem_read_ID_EX),
    .rd_EX_MEM(rd_EX_MEM), .reg_write_EX_MEM(reg_write_EX_MEM),
    .rd_MEM_WB(rd_MEM_WB), .reg_write_MEM_WB(reg_write_MEM_WB),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_done(mc_done),
    .forward_A(forward_A), .forward_B(forward_B),
    .stall(stall), .flush_ID_EX(flush_ID_EX),
    .mc_busy(mc_busy), .mc_timeout(mc_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after another unit.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {rs1_ID, rs2_ID, rs1_ID_EX, rs2_ID_EX, rd_ID_EX, rd_EX_MEM, rd_MEM_WB, mc_rd} = '0;
    {mc_ID, reg_write_ID_EX, mem_read_ID_EX, reg_write_EX_MEM, reg_write_MEM_WB} = '0;
    mc_issue = 1'b0;
    mc_done  = 1'b0;
    #3;
    check("rst_fwdA",    16'(forward_A), 16'd0);
    check("rst_stall",   16'(stall), 16'd0);
    check("rst_busy",    16'(mc_busy), 16'd0);
    check("rst_timeout", 16'(mc_timeout), 16'd0);
    check("rst_cnt",     stall_cnt, 16'd0);
    #9 rst_n = 1'b1;
    tick();

    // Forwarding priority and x0 handling.
    rs1_ID_EX = 5'd5; rd_EX_MEM = 5'd5; rd_MEM_WB = 5'd5;
    reg_write_EX_MEM = 1'b1; reg_write_MEM_WB = 1'b1;
    #1 check("fwdA_exmem_wins", 16'(forward_A), 16'd2);
    rd_EX_MEM = 5'd6;
    #1 check("fwdA_memwb", 16'(forward_A), 16'd1);
    reg_write_MEM_WB = 1'b0;
    #1 check("fwdA_none", 16'(forward_A), 16'd0);
    rs2_ID_EX = 5'd0; rd_EX_MEM = 5'd0; rd_MEM_WB = 5'd0; reg_write_MEM_WB = 1'b1;
    #1 check("fwdB_x0", 16'(forward_B), 16'd0);
    rs2_ID_EX = 5'd6; rd_EX_MEM = 5'd6;
    #1 check("fwdB_exmem", 16'(forward_B), 16'd2);
    reg_write_EX_MEM = 1'b0; rd_MEM_WB = 5'd6;
    #1 check("fwdB_memwb", 16'(forward_B), 16'd1);
    check("fwd_no_stall", 16'(stall), 16'd0);

    // Load-use: one stalled cycle, counted once.
    tick();
    mem_read_ID_EX = 1'b1; reg_write_ID_EX = 1'b1; rd_ID_EX = 5'd7; rs2_ID = 5'd7;
    #1 check("lu_stall", 16'(stall), 16'd1);
    check("lu_flush", 16'(flush_ID_EX), 16'd1);
    tick();
    mem_read_ID_EX = 1'b0; reg_write_ID_EX = 1'b0; rd_ID_EX = 5'd0; rs2_ID = 5'd0;
    #1 check("lu_released", 16'(stall), 16'd0);
    check("lu_cnt", stall_cnt, 16'd1);
    mem_read_ID_EX = 1'b1; reg_write_ID_EX = 1'b1;
    #1 check("lu_x0_no_stall", 16'(stall), 16'd0);
    mem_read_ID_EX = 1'b0; reg_write_ID_EX = 1'b0;

    // Scoreboard RAW on a multi-cycle destination.
    tick();
    mc_issue = 1'b1; mc_rd = 5'd9;
    #1 check("mc_issue_not_busy_yet", 16'(mc_busy), 16'd0);
    tick();
    mc_issue = 1'b0; rs1_ID = 5'd9;
    #1 check("mc_busy", 16'(mc_busy), 16'd1);
    check("raw_stall", 16'(stall), 16'd1);
    tick();
    check("raw_hold", 16'(stall), 16'd1);
    tick();
    mc_done = 1'b1;
    #1 check("raw_done_cycle_stall", 16'(stall), 16'd1);
    check("raw_done_cycle_busy", 16'(mc_busy), 16'd1);
    tick();
    mc_done = 1'b0;
    check("raw_busy_fall", 16'(mc_busy), 16'd0);
    check("raw_stall_fall", 16'(stall), 16'd0);
    check("raw_cnt", stall_cnt, 16'd4);
    rs1_ID = 5'd0;

    // Watchdog: 64 busy cycles with no completion.
    mc_issue = 1'b1; mc_rd = 5'd3;
    tick();
    mc_issue = 1'b0;
    check("wd_busy", 16'(mc_busy), 16'd1);
    mc_ID = 1'b1;
    #1 check("mc_id_busy_stall", 16'(stall), 16'd1);
    mc_ID = 1'b0;
    #1 check("mc_id_clear", 16'(stall), 16'd0);
    repeat (63) tick();
    check("wd_before", 16'(mc_timeout), 16'd0);
    tick();
    check("wd_fire", 16'(mc_timeout), 16'd1);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    check("wd_sticky", 16'(mc_timeout), 16'd1);
    check("wd_idle", 16'(mc_busy), 16'd0);
    check("wd_cnt_unchanged", stall_cnt, 16'd4);

    // Same-register set and clear: set wins; then reset mid-operation.
    mc_issue = 1'b1; mc_rd = 5'd9;
    tick();
    mc_done = 1'b1;
    tick();
    mc_issue = 1'b0; mc_done = 1'b0;
    check("setwins_busy", 16'(mc_busy), 16'd1);
    rs1_ID = 5'd9;
    #1 check("setwins_stall", 16'(stall), 16'd1);
    rst_n = 1'b0;
    #1 check("rst_mid_busy", 16'(mc_busy), 16'd0);
    check("rst_mid_stall", 16'(stall), 16'd0);
    check("rst_mid_timeout", 16'(mc_timeout), 16'd0);
    check("rst_mid_cnt", stall_cnt, 16'd0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_no_pending", 16'(stall), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
